mux4_rr_arbiter: RTL and testbench
==================================

# mux4_rr_arbiter

Round-robin arbiter and sequencer for the 4:1 single-bit multiplexer datapath. Four requesters compete for the shared mux output. The block grants one at a time, holds the grant while the owner keeps requesting, and drives the mux select from the registered grant. It sits between requester logic and the mux and owns the only path to the shared output `f`.

## Interface
Parameters:
- `MAX_HOLD`, default 8: maximum consecutive grant cycles before a forced rotation. Valid range 2..255. Used only when the timeout feature is compiled in.

Ports:
- `clk`  input  1: single clock, rising edge.
- `rst`  input  1: asynchronous, active-high reset.
- `req`  input  4: request lines. Bit i belongs to requester i. Level-sensitive and held for the whole transfer.
- `din`  input  4: data inputs. `din[0..3]` correspond to mux inputs a, b, c, d.
- `gnt`  output 4: one-hot grant, registered.
- `sin`  output 2: mux select, registered, equal to the index of the `gnt` bit.
- `busy` output 1: high while any grant is active.
- `f`    output 1: equals `din[sin]` when `busy`, otherwise 0. Combinational from registered `sin`/`busy`.

## Operation
- States: `IDLE` (no grant) and `GRANT` (exactly one `gnt` bit set).
- Priority pointer `last` (2 bits) holds the most recently granted index. Search order is `last+1, last+2, last+3, last`, all mod 4.
- `IDLE`:
  - If `req != 0`, at the next edge grant the first requester in search order and go to `GRANT`.
  - Set `last` to that index.
- `GRANT`, owner `k`:
  - If `req[k] == 1`, hold the grant.
  - If `req[k] == 0`, release at the next edge:
    - If any other request is pending, grant the next requester in search order (measured from `k`) at that same edge, with no idle cycle. Stay in `GRANT`.
    - Otherwise go to `IDLE`, with `gnt = 0` and `sin` unchanged.
- Requests from non-owners never preempt the owner, except through the timeout feature.
- `f` follows `din[sin]` combinationally while busy. Changes on `din` appear on `f` within the same cycle.
- Reset values:
  - `gnt = 0`, `sin = 0`, `busy = 0`, `f = 0`.
  - State `IDLE`.
  - `last = 3`, so requester 0 has highest priority first.
  - Hold counter = 0.
- Reset asserted mid-grant clears the grant immediately (asynchronously), without waiting for a clock edge.

## Timing
- Grant latency is 1 cycle. A request sampled high at edge n gives `gnt`/`sin`/`busy` valid after edge n.
- Release latency is 1 cycle. Owner `req` sampled low at edge n drops or moves `gnt` after edge n.
- Owner handover is zero-bubble. `busy` stays high across back-to-back grants.
- Requests that rise and fall between two edges are not seen. Requesters must hold `req` until granted.
- Simultaneous requests: exactly one bit of `gnt` is set, chosen by pointer order.
- `sin` only changes at an edge that sets a new `gnt` bit.

## Configuration
Macro `MUX4_ARB_TIMEOUT_EN`.
- **Defined:**
  - An 8-bit hold counter clears at each new grant and increments every cycle in `GRANT`.
  - When the counter equals `MAX_HOLD-1` and another requester is pending, the owner is revoked at the next edge. The next requester in order is granted.
  - If no other requester is pending, the grant continues and the counter saturates at `MAX_HOLD-1`.
  - A revoked owner that still requests takes its normal turn in the rotation.
- **Undefined:**
  - No counter is built.
  - The grant is held for as long as the owner requests.
  - `MAX_HOLD` is ignored.

## Structure
- Shared package `mux4_arb_pkg`:
  - state enum `{IDLE, GRANT}`
  - `IDX_W = 2`
  - `N_REQ = 4`
  - function `next_req(req, last)` returning the index and a found flag.
- Sub-module `mux4_sel`: the pure 4:1 select of `din` by `sin`, instantiated once. It follows the existing sum-of-products mux equation. The arbiter gates its output with `busy`.

## Test plan
- **Reset then request:** reset, then `req = 4'b0001`, `din = 4'b0001`. Expect `gnt = 0001`, `sin = 0`, `busy = 1` after 1 edge, and `f = 1`. Drop `req`: `gnt = 0` and `f = 0` after 1 edge.
- **Simultaneous requests:** after reset, `req = 4'b1111` and each owner drops its request after 2 cycles. Expect grant order 0, 1, 2, 3 with zero-bubble handover, `busy` continuously high, and `sin` sequence 0, 1, 2, 3.
- **Pointer rotation:** grant 2 completes, then `req = 4'b0101`. Expect the next grant to be 0 (search order 3, 0, 1, 2) and `sin = 0`.
- **Data pass-through:** hold a grant on requester 3 and toggle `din[3]` each cycle. `f` tracks the toggles in the same cycle. Toggling `din[0..2]` leaves `f` unaffected.
- **Timeout (`MUX4_ARB_TIMEOUT_EN`, `MAX_HOLD = 4`):**
  - `req = 4'b0011` held.
  - Expect `gnt` alternating `0001` and `0010` every 4 cycles.
  - With only `req = 0001` held, expect the grant to persist for more than 20 cycles.
- **Reset mid-grant:** assert `rst` between edges while `gnt = 0100`. Expect `gnt = 0`, `busy = 0`, `f = 0` immediately. After release with `req = 0100`, expect a fresh grant one edge later.

Source files
------------

// File: rtl/mux4_arb_pkg.sv
// Shared types and helpers for the 4:1 mux round-robin arbiter.
// Holds the FSM state enum, widths and the rotating priority search.
package mux4_arb_pkg;

   localparam int IDX_W = 2;
   localparam int N_REQ = 4;

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

   typedef struct packed {
      logic             found;
      logic [IDX_W-1:0] idx;
   } pick_t;

   // First set bit of req in order last+1, last+2, last+3, last.
   function automatic pick_t next_req(
      input logic [N_REQ-1:0] req,
      input logic [IDX_W-1:0] last
   );
      pick_t            r;
      logic [IDX_W-1:0] c;
      r.found = 1'b0;
      r.idx   = '0;
      for (int i = 1; i <= N_REQ; i++) begin
         c = last + IDX_W'(i);
         if (!r.found && req[c]) begin
            r.found = 1'b1;
            r.idx   = c;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/mux4_sel.sv
// Pure 4:1 single-bit select of din by sin.
// Sum-of-products form of the original datapath mux.
module mux4_sel
   import mux4_arb_pkg::*;
(
   input  logic [IDX_W-1:0] sin,
   input  logic [N_REQ-1:0] din,
   output logic             y
);

   assign y = (~sin[1] & ~sin[0] & din[0])
            | (~sin[1] &  sin[0] & din[1])
            | ( sin[1] & ~sin[0] & din[2])
            | ( sin[1] &  sin[0] & din[3]);

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the shared 4:1 mux output f.
// Optional hold timeout compiled in with MUX4_ARB_TIMEOUT_EN.
module mux4_rr_arbiter
   import mux4_arb_pkg::*;
#(
   parameter int MAX_HOLD = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] din,
   output logic [N_REQ-1:0] gnt,
   output logic [IDX_W-1:0] sin,
   output logic             busy,
   output logic             f
);

   if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
      $error("MAX_HOLD out of range 2..255");
   end

   state_t           state, state_n;
   logic [N_REQ-1:0] gnt_n;
   logic [IDX_W-1:0] sin_n;
   logic [IDX_W-1:0] last, last_n;
   pick_t            pick_i, pick_o;
   logic             rel;
   logic             y;

`ifdef MUX4_ARB_TIMEOUT_EN
   localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);
   logic [7:0] cnt, cnt_n;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         gnt   <= '0;
         sin   <= '0;
         last  <= IDX_W'(N_REQ - 1);
`ifdef MUX4_ARB_TIMEOUT_EN
         cnt   <= '0;
`endif
      end else begin
         state <= state_n;
         gnt   <= gnt_n;
         sin   <= sin_n;
         last  <= last_n;
`ifdef MUX4_ARB_TIMEOUT_EN
         cnt   <= cnt_n;
`endif
      end
   end

   always_comb begin
      state_n = state;
      gnt_n   = gnt;
      sin_n   = sin;
      last_n  = last;
      rel     = 1'b0;
`ifdef MUX4_ARB_TIMEOUT_EN
      cnt_n   = cnt;
`endif
      pick_i  = next_req(req, last);
      // Owner is masked so a revoked owner rejoins at its normal turn.
      pick_o  = next_req(req & ~gnt, sin);
      unique case (state)
         IDLE: begin
            if (pick_i.found) begin
               state_n = GRANT;
               gnt_n   = N_REQ'(1) << pick_i.idx;
               sin_n   = pick_i.idx;
               last_n  = pick_i.idx;
`ifdef MUX4_ARB_TIMEOUT_EN
               cnt_n   = '0;
`endif
            end
         end
         GRANT: begin
            rel = !req[sin];
`ifdef MUX4_ARB_TIMEOUT_EN
            if (cnt == HOLD_LIM && pick_o.found)
               rel = 1'b1;
            else if (cnt != HOLD_LIM)
               cnt_n = cnt + 8'd1;
`endif
            if (rel) begin
               if (pick_o.found) begin
                  gnt_n  = N_REQ'(1) << pick_o.idx;
                  sin_n  = pick_o.idx;
                  last_n = pick_o.idx;
`ifdef MUX4_ARB_TIMEOUT_EN
                  cnt_n  = '0;
`endif
               end else begin
                  state_n = IDLE;
                  gnt_n   = '0;
               end
            end
         end
      endcase
   end

   mux4_sel u_sel (
      .sin (sin),
      .din (din),
      .y   (y)
   );

   always_comb begin
      busy = (state == GRANT);
      f    = busy & y;
   end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed self-checking bench for mux4_rr_arbiter.
// Define MUX4_ARB_TIMEOUT_EN to exercise the hold timeout.
module tb_mux4_rr_arbiter;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic [3:0] din;
   logic [3:0] gnt;
   logic [1:0] sin;
   logic       busy;
   logic       f;

   int n_cmp;
   int n_bad;

   mux4_rr_arbiter #(.MAX_HOLD(4)) dut (
      .clk  (clk),
      .rst  (rst),
      .req  (req),
      .din  (din),
      .gnt  (gnt),
      .sin  (sin),
      .busy (busy),
      .f    (f)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(
      input string      tag,
      input logic [7:0] got,
      input logic [7:0] exp
   );
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst   = 1'b1;
      req   = '0;
      din   = '0;

      // Reset values
      tick();
      tick();
      check("rst_gnt", 8'(gnt), 8'h0);
      check("rst_sin", 8'(sin), 8'h0);
      check("rst_busy", 8'(busy), 8'h0);
      check("rst_f", 8'(f), 8'h0);
      rst = 1'b0;

      // Reset then request
      req = 4'b0001;
      din = 4'b0001;
      #1;
      check("lat_gnt", 8'(gnt), 8'h0);
      tick();
      check("t1_gnt", 8'(gnt), 8'h1);
      check("t1_sin", 8'(sin), 8'h0);
      check("t1_busy", 8'(busy), 8'h1);
      check("t1_f", 8'(f), 8'h1);
      req = 4'b0000;
      tick();
      check("t1_rel_gnt", 8'(gnt), 8'h0);
      check("t1_rel_f", 8'(f), 8'h0);
      check("t1_rel_busy", 8'(busy), 8'h0);

      // Simultaneous requests, zero-bubble handover 0,1,2,3
      do_reset();
      req = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         tick();
         check($sformatf("sim%0d_gnt", k), 8'(gnt), 8'(1 << k));
         check($sformatf("sim%0d_sin", k), 8'(sin), 8'(k));
         check($sformatf("sim%0d_busy", k), 8'(busy), 8'h1);
         tick();
         check($sformatf("sim%0d_hold", k), 8'(gnt), 8'(1 << k));
         req[k] = 1'b0;
      end
      tick();
      check("sim_end_gnt", 8'(gnt), 8'h0);
      check("sim_end_sin", 8'(sin), 8'h3);

      // Pointer rotation: after grant 2, 0101 goes to 0
      do_reset();
      req = 4'b0100;
      tick();
      check("rot_g2", 8'(gnt), 8'h4);
      req = 4'b0000;
      tick();
      check("rot_idle", 8'(gnt), 8'h0);
      check("rot_idle_sin", 8'(sin), 8'h2);
      req = 4'b0101;
      tick();
      check("rot_gnt", 8'(gnt), 8'h1);
      check("rot_sin", 8'(sin), 8'h0);
      req = 4'b0000;
      tick();

      // Data pass-through on requester 3
      req = 4'b1000;
      tick();
      check("dp_gnt", 8'(gnt), 8'h8);
      check("dp_sin", 8'(sin), 8'h3);
      for (int i = 0; i < 6; i++) begin
         din = {i[0], 3'(i * 3 + 5)};
         #1;
         check($sformatf("dp_f%0d", i), 8'(f), 8'(i[0]));
         din[2:0] = ~din[2:0];
         #1;
         check($sformatf("dp_fo%0d", i), 8'(f), 8'(i[0]));
         tick();
         check($sformatf("dp_hold%0d", i), 8'(gnt), 8'h8);
      end
      req = 4'b0000;
      din = 4'b0000;
      tick();

`ifdef MUX4_ARB_TIMEOUT_EN
      // Timeout rotation with MAX_HOLD = 4
      do_reset();
      req = 4'b0011;
      for (int c = 0; c < 12; c++) begin
         tick();
         check($sformatf("to_gnt%0d", c), 8'(gnt),
               ((c / 4) % 2 == 1) ? 8'h2 : 8'h1);
      end
      req = 4'b0001;
      for (int c = 0; c < 25; c++) begin
         tick();
         check($sformatf("to_solo%0d", c), 8'(gnt), 8'h1);
      end
`else
      // Without timeout the owner is never preempted
      do_reset();
      req = 4'b0011;
      for (int c = 0; c < 25; c++) begin
         tick();
         check($sformatf("nopre%0d", c), 8'(gnt), 8'h1);
      end
      req = 4'b0010;
      tick();
      check("nopre_hand", 8'(gnt), 8'h2);
`endif
      req = 4'b0000;
      tick();

      // Reset mid-grant clears immediately
      do_reset();
      req = 4'b0100;
      din = 4'b0100;
      tick();
      check("mr_gnt", 8'(gnt), 8'h4);
      check("mr_f", 8'(f), 8'h1);
      #2;
      rst = 1'b1;
      #1;
      check("mr_rst_gnt", 8'(gnt), 8'h0);
      check("mr_rst_busy", 8'(busy), 8'h0);
      check("mr_rst_f", 8'(f), 8'h0);
      rst = 1'b0;
      #1;
      check("mr_pre_gnt", 8'(gnt), 8'h0);
      tick();
      check("mr_new_gnt", 8'(gnt), 8'h4);
      check("mr_new_sin", 8'(sin), 8'h2);
      check("mr_new_f", 8'(f), 8'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
